// File: rtl/veda_pkg.sv
// Shared definitions for the VEDA multi-cycle core: opcodes, instruction
// field positions and the fetch/execute/memory state encoding.
package veda_pkg;

  localparam logic [5:0] OP_ADD   = 6'd0;
  localparam logic [5:0] OP_SUB   = 6'd1;
  localparam logic [5:0] OP_ADDU  = 6'd2;
  localparam logic [5:0] OP_SUBU  = 6'd3;
  localparam logic [5:0] OP_ADDI  = 6'd4;
  localparam logic [5:0] OP_ADDIU = 6'd5;
  localparam logic [5:0] OP_AND   = 6'd6;
  localparam logic [5:0] OP_OR    = 6'd7;
  localparam logic [5:0] OP_ANDI  = 6'd8;
  localparam logic [5:0] OP_ORI   = 6'd9;
  localparam logic [5:0] OP_SLL   = 6'd10;
  localparam logic [5:0] OP_SRL   = 6'd11;
  localparam logic [5:0] OP_LW    = 6'd12;
  localparam logic [5:0] OP_SW    = 6'd13;
  localparam logic [5:0] OP_BEQ   = 6'd14;
  localparam logic [5:0] OP_BNE   = 6'd15;
  localparam logic [5:0] OP_BGT   = 6'd16;
  localparam logic [5:0] OP_BGE   = 6'd17;
  localparam logic [5:0] OP_BLT   = 6'd18;
  localparam logic [5:0] OP_BLE   = 6'd19;
  localparam logic [5:0] OP_J     = 6'd20;
  localparam logic [5:0] OP_JR    = 6'd21;
  localparam logic [5:0] OP_JAL   = 6'd22;
  localparam logic [5:0] OP_LI    = 6'd23;
  localparam logic [5:0] OP_SLT   = 6'd24;
  localparam logic [5:0] OP_HALT  = 6'd31;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int SH_HI  = 10;
  localparam int SH_LO  = 6;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM   = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  // Shifts take their amount from r[sh], so read port A is steered to sh.
  function automatic logic is_shift(input logic [5:0] op);
    return (op == OP_SLL) || (op == OP_SRL);
  endfunction

endpackage

// File: rtl/veda_regfile.sv
// 32-entry register file: two asynchronous read ports, one synchronous write
// port, r0 hardwired to zero and reset pattern r[i]=i.
module veda_regfile
  import veda_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      ra_addr_i,
  output logic [XLEN-1:0] ra_data_o,
  input  logic [4:0]      rb_addr_i,
  output logic [XLEN-1:0] rb_data_o,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i
);

  logic [XLEN-1:0] regs_q [32];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= XLEN'(i);
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign ra_data_o = (ra_addr_i == 5'd0) ? '0 : regs_q[ra_addr_i];
  assign rb_data_o = (rb_addr_i == 5'd0) ? '0 : regs_q[rb_addr_i];

endmodule

// File: rtl/veda_mc_core.sv
// Multi-cycle VEDA core: FETCH -> EXEC -> (MEM) -> FETCH with a req/ready
// data-memory port; instruction word arrives one cycle after imem_addr.
module veda_mc_core
  import veda_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int PC_W   = 9,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ready,
  output logic              retire,
  output logic [XLEN-1:0]   wb_data,
  output logic              halted,
  output logic [PC_W-1:0]   pc
);

  localparam int SHW = $clog2(XLEN);

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]     mem_wdata_q, mem_wdata_d;
  logic [4:0]          ld_rt_q, ld_rt_d;
  logic                retire_q, retire_d;
  logic [XLEN-1:0]     wb_q, wb_d;
  logic                halted_q, halted_d;

  logic [5:0]          op;
  logic [4:0]          rs, rt, rd, sh, rs_sel;
  logic [XLEN-1:0]     rf_a, rf_b, imm_s, imm_z;
  logic [PC_W-1:0]     pc_inc, pc_br;
  logic [ADDR_W-1:0]   ea;
  logic                br_taken;
  logic                rf_we;
  logic [4:0]          rf_waddr;
  logic [XLEN-1:0]     rf_wdata;

  assign op     = imem_rdata[OP_HI:OP_LO];
  assign rs     = imem_rdata[RS_HI:RS_LO];
  assign rt     = imem_rdata[RT_HI:RT_LO];
  assign rd     = imem_rdata[RD_HI:RD_LO];
  assign sh     = imem_rdata[SH_HI:SH_LO];
  assign imm_s  = {{(XLEN-16){imem_rdata[IMM_HI]}}, imem_rdata[IMM_HI:IMM_LO]};
  assign imm_z  = {{(XLEN-16){1'b0}}, imem_rdata[IMM_HI:IMM_LO]};
  assign rs_sel = is_shift(op) ? sh : rs;
  assign pc_inc = pc_q + PC_W'(1);
  assign pc_br  = pc_q + imm_s[PC_W-1:0];
  assign ea     = ADDR_W'(rf_a + imm_s);

  veda_regfile #(.XLEN(XLEN)) u_rf (
    .clk       (clk),
    .reset     (reset),
    .ra_addr_i (rs_sel),
    .ra_data_o (rf_a),
    .rb_addr_i (rt),
    .rb_data_o (rf_b),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata)
  );

  // Signed branch condition for the six compare-and-branch opcodes.
  always_comb begin
    br_taken = 1'b0;
    case (op)
      OP_BEQ:  br_taken = (rf_a == rf_b);
      OP_BNE:  br_taken = (rf_a != rf_b);
      OP_BGT:  br_taken = ($signed(rf_a) >  $signed(rf_b));
      OP_BGE:  br_taken = ($signed(rf_a) >= $signed(rf_b));
      OP_BLT:  br_taken = ($signed(rf_a) <  $signed(rf_b));
      OP_BLE:  br_taken = ($signed(rf_a) <= $signed(rf_b));
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ld_rt_d     = ld_rt_q;
    retire_d    = 1'b0;
    wb_d        = wb_q;
    halted_d    = halted_q;
    rf_we       = 1'b0;
    rf_waddr    = 5'd0;
    rf_wdata    = '0;
    case (state_q)
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC: begin
        state_d  = ST_FETCH;
        pc_d     = pc_inc;
        retire_d = 1'b1;
        case (op)
          OP_ADD, OP_ADDU: begin rf_we = 1'b1; rf_waddr = rd; rf_wdata = rf_a + rf_b; end
          OP_SUB, OP_SUBU: begin rf_we = 1'b1; rf_waddr = rd; rf_wdata = rf_a - rf_b; end
          OP_AND:   begin rf_we = 1'b1; rf_waddr = rd; rf_wdata = rf_a & rf_b; end
          OP_OR:    begin rf_we = 1'b1; rf_waddr = rd; rf_wdata = rf_a | rf_b; end
          OP_SLL:   begin rf_we = 1'b1; rf_waddr = rd; rf_wdata = rf_b << rf_a[SHW-1:0]; end
          OP_SRL:   begin rf_we = 1'b1; rf_waddr = rd; rf_wdata = rf_b >> rf_a[SHW-1:0]; end
          OP_SLT:   begin rf_we = 1'b1; rf_waddr = rd; rf_wdata = XLEN'($signed(rf_a) < $signed(rf_b)); end
          OP_ADDI:  begin rf_we = 1'b1; rf_waddr = rt; rf_wdata = rf_a + imm_s; end
          OP_ADDIU: begin rf_we = 1'b1; rf_waddr = rt; rf_wdata = rf_a + imm_z; end
          OP_ANDI:  begin rf_we = 1'b1; rf_waddr = rt; rf_wdata = rf_a & imm_z; end
          OP_ORI:   begin rf_we = 1'b1; rf_waddr = rt; rf_wdata = rf_a | imm_z; end
          OP_LI:    begin rf_we = 1'b1; rf_waddr = rt; rf_wdata = imm_z; end
          // Memory ops park in MEM; pc and retire wait for mem_ready.
          OP_LW, OP_SW: begin
            state_d     = ST_MEM;
            pc_d        = pc_q;
            retire_d    = 1'b0;
            mem_req_d   = 1'b1;
            mem_we_d    = (op == OP_SW);
            mem_addr_d  = ea;
            mem_wdata_d = rf_b;
            ld_rt_d     = rt;
          end
          OP_BEQ, OP_BNE, OP_BGT, OP_BGE, OP_BLT, OP_BLE: pc_d = br_taken ? pc_br : pc_inc;
          OP_J:     pc_d = imm_z[PC_W-1:0];
          OP_JR:    pc_d = rf_a[PC_W-1:0];
          OP_JAL: begin
            rf_we    = 1'b1;
            rf_waddr = 5'd31;
            rf_wdata = XLEN'(pc_inc);
            pc_d     = imm_z[PC_W-1:0];
          end
          OP_HALT: begin
            state_d  = ST_HALT;
            pc_d     = pc_q;
            retire_d = 1'b0;
            halted_d = 1'b1;
          end
          default: pc_d = pc_inc;
        endcase
        if (rf_we) begin
          wb_d = rf_wdata;
        end else begin
          wb_d = wb_q;
        end
      end
      ST_MEM: begin
        if (mem_ready) begin
          state_d   = ST_FETCH;
          pc_d      = pc_inc;
          retire_d  = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (!mem_we_q) begin
            rf_we    = 1'b1;
            rf_waddr = ld_rt_q;
            rf_wdata = mem_rdata;
            wb_d     = mem_rdata;
          end else begin
            wb_d = wb_q;
          end
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  // State and registered outputs; reset aborts any pending memory request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_FETCH;
      pc_q        <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ld_rt_q     <= 5'd0;
      retire_q    <= 1'b0;
      wb_q        <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ld_rt_q     <= ld_rt_d;
      retire_q    <= retire_d;
      wb_q        <= wb_d;
      halted_q    <= halted_d;
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign retire    = retire_q;
  assign wb_data   = wb_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_veda_mc_core.sv
// Table-driven bench for veda_mc_core with a retire scoreboard, behavioural
// instruction ROM and a wait-stated data memory.
module tb_veda_mc_core;

  logic        clk;
  logic        reset;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        retire;
  logic [31:0] wb_data;
  logic        halted;
  logic [8:0]  pc;

  veda_mc_core #(.XLEN(32), .PC_W(9), .ADDR_W(9)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .retire     (retire),
    .wb_data    (wb_data),
    .halted     (halted),
    .pc         (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] imem [512];
  logic [31:0] dmem [512];

  always @(posedge clk) imem_rdata <= imem[imem_addr];

  typedef struct {
    logic [31:0] instr;
    logic [31:0] exp_wb;
    logic [8:0]  exp_pc;
    int          delay;
    logic        exp_we;
    logic [8:0]  exp_addr;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   checks;
  int   errors;
  logic [8:0] cur_pc;

  function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh);
    return {op, rs, rt, rd, sh, 6'd0};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [31:0] instr, input logic [31:0] wb, input logic [8:0] npc,
                         input int delay, input logic we, input logic [8:0] addr,
                         input logic [31:0] wdata);
    vec_t v;
    v.instr = instr; v.exp_wb = wb; v.exp_pc = npc; v.delay = delay;
    v.exp_we = we; v.exp_addr = addr; v.exp_wdata = wdata;
    vecs.push_back(v);
  endtask

  // Place one instruction at the current pc, service memory, check at retire.
  task automatic run_instr(input vec_t v);
    vec_t        e;
    int          cycles;
    int          reqcnt;
    logic        got;
    logic [8:0]  cap_addr;
    logic        cap_we;
    logic [31:0] cap_wdata;
    imem[cur_pc] = v.instr;
    sb.push_back(v);
    cycles = 0; reqcnt = 0; got = 1'b0;
    cap_addr = 9'd0; cap_we = 1'b0; cap_wdata = 32'd0;
    while (!got && cycles < 40) begin
      @(negedge clk);
      mem_ready = 1'b0;
      cycles++;
      if (retire) begin
        got = 1'b1;
      end else if (mem_req) begin
        reqcnt++;
        if (reqcnt >= v.delay) begin
          mem_ready = 1'b1;
          cap_addr = mem_addr; cap_we = mem_we; cap_wdata = mem_wdata;
          if (mem_we) dmem[mem_addr] = mem_wdata;
          else mem_rdata = dmem[mem_addr];
        end
      end
    end
    e = sb.pop_front();
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL retire_timeout pc=%0d actual=no_retire required=retire", cur_pc);
    end else begin
      chk($sformatf("wb_data@pc%0d", cur_pc), wb_data, e.exp_wb);
      chk($sformatf("next_pc@pc%0d", cur_pc), {23'd0, pc}, {23'd0, e.exp_pc});
      chk($sformatf("latency@pc%0d", cur_pc), 32'(cycles), 32'(2 + e.delay));
      if (e.delay > 0) begin
        chk($sformatf("req_cycles@pc%0d", cur_pc), 32'(reqcnt), 32'(e.delay));
        chk($sformatf("mem_addr@pc%0d", cur_pc), {23'd0, cap_addr}, {23'd0, e.exp_addr});
        chk($sformatf("mem_we@pc%0d", cur_pc), {31'd0, cap_we}, {31'd0, e.exp_we});
        if (e.exp_we) chk($sformatf("mem_wdata@pc%0d", cur_pc), cap_wdata, e.exp_wdata);
      end
    end
    cur_pc = e.exp_pc;
  endtask

  initial begin
    int   waited;
    int   addr_changes;
    int   retires;
    checks = 0; errors = 0;
    mem_ready = 1'b0; mem_rdata = 32'd0; reset = 1'b1;
    for (int i = 0; i < 512; i++) begin
      imem[i] = 32'hFC00_0000;
      dmem[i] = 32'd0;
    end

    // ALU / immediate / r0 behaviour
    add_vec(rtype(6'd0, 5'd1, 5'd2, 5'd3, 5'd0),   32'h3,        9'd1,   0, 1'b0, 9'd0, 32'd0);
    add_vec(rtype(6'd7, 5'd3, 5'd0, 5'd9, 5'd0),   32'h3,        9'd2,   0, 1'b0, 9'd0, 32'd0);
    add_vec(itype(6'd4, 5'd0, 5'd5, 16'hFFFF),     32'hFFFFFFFF, 9'd3,   0, 1'b0, 9'd0, 32'd0);
    add_vec(rtype(6'd11, 5'd0, 5'd5, 5'd6, 5'd4),  32'h0FFFFFFF, 9'd4,   0, 1'b0, 9'd0, 32'd0);
    add_vec(rtype(6'd10, 5'd0, 5'd5, 5'd10, 5'd4), 32'hFFFFFFF0, 9'd5,   0, 1'b0, 9'd0, 32'd0);
    add_vec(rtype(6'd1, 5'd1, 5'd2, 5'd11, 5'd0),  32'hFFFFFFFF, 9'd6,   0, 1'b0, 9'd0, 32'd0);
    add_vec(rtype(6'd3, 5'd2, 5'd1, 5'd12, 5'd0),  32'h1,        9'd7,   0, 1'b0, 9'd0, 32'd0);
    add_vec(rtype(6'd2, 5'd5, 5'd1, 5'd13, 5'd0),  32'h0,        9'd8,   0, 1'b0, 9'd0, 32'd0);
    add_vec(rtype(6'd6, 5'd7, 5'd6, 5'd14, 5'd0),  32'h7,        9'd9,   0, 1'b0, 9'd0, 32'd0);
    add_vec(rtype(6'd24, 5'd5, 5'd1, 5'd15, 5'd0), 32'h1,        9'd10,  0, 1'b0, 9'd0, 32'd0);
    add_vec(rtype(6'd24, 5'd1, 5'd5, 5'd16, 5'd0), 32'h0,        9'd11,  0, 1'b0, 9'd0, 32'd0);
    add_vec(itype(6'd5, 5'd0, 5'd17, 16'hFFFF),    32'h0000FFFF, 9'd12,  0, 1'b0, 9'd0, 32'd0);
    add_vec(itype(6'd8, 5'd5, 5'd18, 16'h00F0),    32'h000000F0, 9'd13,  0, 1'b0, 9'd0, 32'd0);
    add_vec(itype(6'd9, 5'd1, 5'd19, 16'h0100),    32'h00000101, 9'd14,  0, 1'b0, 9'd0, 32'd0);
    add_vec(itype(6'd23, 5'd0, 5'd20, 16'h8001),   32'h00008001, 9'd15,  0, 1'b0, 9'd0, 32'd0);
    add_vec(rtype(6'd0, 5'd1, 5'd2, 5'd0, 5'd0),   32'h3,        9'd16,  0, 1'b0, 9'd0, 32'd0);
    add_vec(rtype(6'd7, 5'd0, 5'd0, 5'd21, 5'd0),  32'h0,        9'd17,  0, 1'b0, 9'd0, 32'd0);
    add_vec(32'h6400_0000,                         32'h0,        9'd18,  0, 1'b0, 9'd0, 32'd0);
    // Control flow
    add_vec(itype(6'd20, 5'd0, 5'd0, 16'd30),      32'h0,        9'd30,  0, 1'b0, 9'd0, 32'd0);
    add_vec(itype(6'd14, 5'd1, 5'd2, 16'd5),       32'h0,        9'd31,  0, 1'b0, 9'd0, 32'd0);
    add_vec(itype(6'd15, 5'd1, 5'd2, 16'd4),       32'h0,        9'd35,  0, 1'b0, 9'd0, 32'd0);
    add_vec(itype(6'd16, 5'd2, 5'd1, 16'd2),       32'h0,        9'd37,  0, 1'b0, 9'd0, 32'd0);
    add_vec(itype(6'd17, 5'd1, 5'd1, 16'hFFF9),    32'h0,        9'd30,  0, 1'b0, 9'd0, 32'd0);
    add_vec(itype(6'd19, 5'd2, 5'd1, 16'd9),       32'h0,        9'd31,  0, 1'b0, 9'd0, 32'd0);
    add_vec(itype(6'd17, 5'd5, 5'd1, 16'd4),       32'h0,        9'd32,  0, 1'b0, 9'd0, 32'd0);
    add_vec(itype(6'd20, 5'd0, 5'd0, 16'd20),      32'h0,        9'd20,  0, 1'b0, 9'd0, 32'd0);
    add_vec(itype(6'd22, 5'd0, 5'd0, 16'd40),      32'd21,       9'd40,  0, 1'b0, 9'd0, 32'd0);
    add_vec(itype(6'd21, 5'd31, 5'd0, 16'd0),      32'd21,       9'd21,  0, 1'b0, 9'd0, 32'd0);
    add_vec(itype(6'd20, 5'd0, 5'd0, 16'd5),       32'd21,       9'd5,   0, 1'b0, 9'd0, 32'd0);
    add_vec(itype(6'd18, 5'd1, 5'd2, 16'hFFFD),    32'd21,       9'd2,   0, 1'b0, 9'd0, 32'd0);
    add_vec(itype(6'd20, 5'd0, 5'd0, 16'd5),       32'd21,       9'd5,   0, 1'b0, 9'd0, 32'd0);
    add_vec(itype(6'd14, 5'd1, 5'd2, 16'd7),       32'd21,       9'd6,   0, 1'b0, 9'd0, 32'd0);
    add_vec(itype(6'd20, 5'd0, 5'd0, 16'h01FF),    32'd21,       9'd511, 0, 1'b0, 9'd0, 32'd0);
    add_vec(32'hFC00_0000,                         32'd21,       9'd0,   0, 1'b0, 9'd0, 32'd0);
    add_vec(rtype(6'd7, 5'd31, 5'd0, 5'd22, 5'd0), 32'd21,       9'd1,   0, 1'b0, 9'd0, 32'd0);
    // Loads and stores with wait states
    add_vec(itype(6'd13, 5'd0, 5'd7, 16'd10),      32'd21,       9'd2,   3, 1'b1, 9'd10,  32'd7);
    add_vec(itype(6'd12, 5'd0, 5'd8, 16'd10),      32'd7,        9'd3,   1, 1'b0, 9'd10,  32'd0);
    add_vec(itype(6'd12, 5'd5, 5'd23, 16'd11),     32'd7,        9'd4,   2, 1'b0, 9'd10,  32'd0);
    add_vec(rtype(6'd7, 5'd8, 5'd0, 5'd24, 5'd0),  32'd7,        9'd5,   0, 1'b0, 9'd0, 32'd0);
    add_vec(itype(6'd13, 5'd1, 5'd2, 16'hFFFE),    32'd7,        9'd6,   1, 1'b1, 9'd511, 32'd2);
    add_vec(itype(6'd12, 5'd0, 5'd25, 16'h01FF),   32'd2,        9'd7,   2, 1'b0, 9'd511, 32'd0);

    repeat (3) @(negedge clk);
    chk("rst_pc", {23'd0, pc}, 32'd0);
    chk("rst_imem_addr", {23'd0, imem_addr}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {23'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_retire", {31'd0, retire}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    cur_pc = 9'd0;
    reset = 1'b0;

    foreach (vecs[i]) run_instr(vecs[i]);

    // Reset while a load is stalled on mem_ready
    imem[cur_pc] = itype(6'd12, 5'd0, 5'd9, 16'd10);
    repeat (5) @(negedge clk);
    chk("stall_mem_req", {31'd0, mem_req}, 32'd1);
    chk("stall_retire", {31'd0, retire}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_mem_req", {31'd0, mem_req}, 32'd0);
    chk("abort_pc", {23'd0, pc}, 32'd0);
    chk("abort_wb_data", wb_data, 32'd0);
    reset = 1'b0;
    cur_pc = 9'd0;
    begin
      vec_t v;
      v.instr = rtype(6'd7, 5'd9, 5'd0, 5'd26, 5'd0); v.exp_wb = 32'd9; v.exp_pc = 9'd1;
      v.delay = 0; v.exp_we = 1'b0; v.exp_addr = 9'd0; v.exp_wdata = 32'd0;
      run_instr(v);
    end

    // Halt freezes the pc and stops fetching
    imem[cur_pc] = 32'h7C00_0000;
    waited = 0;
    while (!halted && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    chk("halted", {31'd0, halted}, 32'd1);
    chk("halt_imem_addr", {23'd0, imem_addr}, 32'd1);
    addr_changes = 0;
    retires = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_addr !== 9'd1) addr_changes++;
      if (retire) retires++;
    end
    chk("halt_addr_changes", 32'(addr_changes), 32'd0);
    chk("halt_retires", 32'(retires), 32'd0);
    chk("halt_sticky", {31'd0, halted}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/veda_mc_core.md
# veda_mc_core

Parametrised multi-cycle successor to the single-cycle VEDA ALU/branch datapath. It executes the existing 6-bit-opcode VEDA instruction set (ALU, immediate, shift, load/store, branch, jump, slt, load-immediate, halt) through a fetch/execute/memory state machine. It talks to an external instruction memory and to a separate data memory over a req/ready handshake, so wait-stated memories are supported. It sits between the instruction ROM and the data RAM at the top of the processor subsystem.

## Interface
- XLEN, 32: datapath and register width (≥16)
- PC_W, 9: program-counter / instruction-address width
- ADDR_W, 9: data-memory word-address width
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- imem_addr  out  PC_W  instruction address (=pc)
- imem_rdata  in  32  instruction word, valid one cycle after imem_addr
- mem_req  out  1  data-memory request
- mem_we  out  1  1=store, 0=load; valid with mem_req
- mem_addr  out  ADDR_W  data word address
- mem_wdata  out  XLEN  store data
- mem_rdata  in  XLEN  load data, valid when mem_ready
- mem_ready  in  1  completes the current request
- retire  out  1  one-cycle pulse per completed instruction
- wb_data  out  XLEN  last value written to the register file
- halted  out  1  core stopped by opcode 31
- pc  out  PC_W  current pc

## Operation
- Fields: op[31:26], rs[25:21], rt[20:16], rd[15:11], sh[10:6], imm[15:0]. sext/zext = sign/zero extension to XLEN.
- Register file: 32×XLEN. On reset, r[i]=i. r0 ignores writes and always reads 0.
- R-type ops write rd: 0 add, 1 sub, 2 addu, 3 subu, 6 and, 7 or, 10 sll (r[rt] << r[sh][log2 XLEN-1:0]), 11 srl (logical), 24 slt (signed; result 1/0).
- I-type ops write rt: 4 addi (sext), 5 addiu (zext), 8 andi (zext), 9 ori (zext), 23 li (rt=zext imm).
- Add and sub wrap modulo 2^XLEN. There is no overflow trap.
- 12 lw: rt=mem[ea]. 13 sw: mem[ea]=r[rt]. ea=(r[rs]+sext imm) truncated to ADDR_W.
- Branches compare r[rs] and r[rt] as signed values. If taken, pc=pc+sext(imm) mod 2^PC_W; otherwise pc=pc+1. Ops: 14 beq, 15 bne, 16 bgt, 17 bge, 18 blt, 19 ble.
- Jumps: 20 j (pc=imm[PC_W-1:0]); 21 jr (pc=r[rs][PC_W-1:0]); 22 jal (r31=pc+1, then pc=imm).
- 31 halt: halted=1, pc frozen, no further fetch until reset.
- Any other opcode is a NOP: pc+1, retire pulses.
- FSM states: FETCH → EXEC → (MEM for lw/sw) → FETCH, plus HALT.
  - FETCH: drive imem_addr=pc.
  - EXEC: latch and decode the instruction, perform the ALU, branch or jump operation, and write back.
  - MEM: hold mem_req, mem_we, mem_addr and mem_wdata stable until mem_ready=1. On the ready cycle, lw writes rt, pc advances and the FSM returns to FETCH.
- pc+1 wraps modulo 2^PC_W.

## Timing
- Reset values: state=FETCH, pc=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, retire=0, wb_data=0, halted=0; imem_addr=0.
- Non-memory instruction: 2 cycles. retire and the register write occur at the end of EXEC.
- lw/sw: 2+N cycles, N≥1 = cycles in MEM including the mem_ready cycle. mem_req rises the cycle after EXEC.
- mem_ready sampled while mem_req=0 is ignored. mem_ready held low stalls the core indefinitely.
- Reset asserted mid-MEM: mem_req=0 the next cycle, the register write is not performed, and all reset values apply.
- A write to r0 leaves r0=0, but wb_data still shows the computed value.
- Register read-after-write: the new value is visible to the next instruction. There is no bypass logic because execution is serialised.

## Structure
- Package veda_pkg holds the opcode localparams (0–24, 31), the FSM state enum, and the field bit positions.
- One sub-module, veda_regfile: 32×XLEN with 2 async read ports and 1 sync write port. It implements r0 hardwiring and the reset pattern r[i]=i.
- ALU and branch compare stay inline in the core.

## Test plan
- Reset, then add r3=r1+r2 (op 0, rs=1, rt=2, rd=3) → wb_data=3, retire pulses 2 cycles after fetch, r3=3.
- addi r5,r0,-1 with XLEN=32, then srl r6=r5>>r4 (r4=4) → r5=32'hFFFFFFFF, r6=32'h0FFFFFFF.
- sw r7→ea 10 with mem_ready delayed 3 cycles → mem_req high 3 cycles, mem_addr=10, mem_wdata=7. Then lw r8 from ea 10 with memory returning 7 → r8=7.
- Taken blt r1,r2,imm=-3 at pc=5 → next fetch at pc=2. Not-taken beq r1,r2 → next fetch at pc=6.
- jal at pc=20, imm=40 → r31=21, pc=40. Then jr r31 → pc=21. With PC_W=9, pc=511 followed by a NOP → pc=0.
- Reset during a stalled lw → mem_req low next cycle, target rt unchanged (=i), pc=0. Separately, op 31 → halted=1 with no further imem_addr change.
